fetch_unit: RTL

- PC register and instruction-fetch front end of the RV32 core. Sits directly upstream of decode and the branch/jump resolver.
- Consumes the resolver's redirect (take / next PC) and issues in-order requests to instruction memory with a valid/ready handshake.
- Tracks in-flight requests and discards wrong-path responses after a redirect.
- Buffers fetched instructions, tagged with their PC, in a small FIFO and hands them to decode through a valid/ready handshake.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// RV32 fetch front end: PC register, in-order IMEM requests, wrong-path drop and a PC-tagged instruction FIFO.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and raise a sticky fetch_misaligned flag.
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fetch_misaligned
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] fifo_count;
   logic [PW-1:0] fifo_rd, fifo_wr;
   logic [PW-1:0] tag_rd, tag_wr;
   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic [31:0]   tag_q      [FIFO_DEPTH];
   logic [CW:0]   credit_used;
   logic [31:0]   redirect_target;
   logic          misaligned;
   logic          req_fire, rsp_keep, rsp_drop, pop, rsp_count;

   // In-flight requests reserve FIFO slots so a kept response always has room.
   assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = !rst && !redirect_valid && !misaligned
                           && (outstanding < CW'(MAX_OUTSTANDING))
                           && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
   assign rsp_count      = imem_rsp_valid && (outstanding != '0);

   assign instr_valid    = (fifo_count != '0) && !redirect_valid;
   assign instr          = (fifo_count != '0) ? fifo_instr[fifo_rd] : '0;
   assign instr_pc       = (fifo_count != '0) ? fifo_pc[fifo_rd]    : '0;
   assign pop            = instr_valid && instr_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redirect_target = redirect_pc;

   always_ff @(posedge clk) begin
      if (rst)
         misaligned <= 1'b0;
      else if (redirect_valid)
         misaligned <= (redirect_pc[1:0] != 2'b00);
   end
`else
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
   assign misaligned      = 1'b0;
`endif

   assign fetch_misaligned = misaligned;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_count  <= '0;
         fifo_rd     <= '0;
         fifo_wr     <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_count);
         if (redirect_valid) begin
            // Everything still in flight belongs to the wrong path, including a response landing now.
            fetch_pc   <= redirect_target;
            drop_cnt   <= outstanding - CW'(rsp_count);
            fifo_count <= '0;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            tag_rd     <= '0;
            tag_wr     <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
               tag_wr   <= tag_wr + PW'(1);
            end
            if (rsp_drop)
               drop_cnt <= drop_cnt - CW'(1);
            if (rsp_keep) begin
               tag_rd  <= tag_rd + PW'(1);
               fifo_wr <= fifo_wr + PW'(1);
            end
            if (pop)
               fifo_rd <= fifo_rd + PW'(1);
            fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire)
         tag_q[tag_wr] <= fetch_pc;
      if (rsp_keep) begin
         fifo_instr[fifo_wr] <= imem_rsp_data;
         fifo_pc[fifo_wr]    <= tag_q[tag_rd];
      end
   end
endmodule
